// File: rtl/shift_unit_if.sv
// Request/response bundle for shift_unit: operand request channel in, shifted result channel out.
interface shift_unit_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned AW    = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [AW-1:0]    in_shamt;
   logic [1:0]       in_mode;
   logic             in_carry;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic             out_zero;

   modport master (
      output in_valid, in_data, in_shamt, in_mode, in_carry, out_ready,
      input  in_ready, out_valid, out_data, out_carry, out_zero
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, in_carry, out_ready,
      output in_ready, out_valid, out_data, out_carry, out_zero
   );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle shifter: applies one power-of-two stage per cycle, selected by the shift-amount bit,
// and stops after the most significant set bit of the shift amount.
module shift_unit #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned AW    = $clog2(WIDTH)
) (
   input logic       clk,
   input logic       reset_n,
   input logic       flush,
   shift_unit_if.slave bus
);

   if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("shift_unit: WIDTH must be a power of two >= 2");
   end
   if (AW != $clog2(WIDTH)) begin : g_bad_aw
      $error("shift_unit: AW is derived from WIDTH and must not be overridden");
   end

   localparam logic [1:0] ModeLsl = 2'b00;
   localparam logic [1:0] ModeLsr = 2'b01;
   localparam logic [1:0] ModeAsr = 2'b10;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] data_q;
   logic             carry_q;
   logic             zero_q;
   logic             valid_q;
   logic             ready_q;
   logic [1:0]       mode_q;
   logic [AW-1:0]    rem_q;
   logic [AW-1:0]    k_q;

   logic [WIDTH-1:0] stage_data [AW];
   logic [AW-1:0]    stage_carry;
   logic [WIDTH-1:0] sel_data;
   logic             sel_carry;
   logic [WIDTH-1:0] step_data;
   logic             step_carry;
   logic             last_stage;

   // One fixed-distance shifter per stage; only the one matching k is used each cycle.
   for (genvar g = 0; g < AW; g++) begin : g_stage
      localparam int unsigned Sh = 1 << g;
      logic [WIDTH-1:0] lsl_val;
      logic [WIDTH-1:0] lsr_val;
      logic [WIDTH-1:0] asr_val;
      logic [WIDTH-1:0] ror_val;

      assign lsl_val = data_q << Sh;
      assign lsr_val = data_q >> Sh;
      assign asr_val = $signed(data_q) >>> Sh;
      assign ror_val = (data_q >> Sh) | (data_q << (WIDTH - Sh));

      assign stage_data[g] = (mode_q == ModeLsl) ? lsl_val :
                             (mode_q == ModeLsr) ? lsr_val :
                             (mode_q == ModeAsr) ? asr_val : ror_val;
      // Right shifts and rotate all expose bit Sh-1 as the last bit out.
      assign stage_carry[g] = (mode_q == ModeLsl) ? data_q[WIDTH-Sh] : data_q[Sh-1];
   end

   always_comb begin
      sel_data  = data_q;
      sel_carry = carry_q;
      for (int i = 0; i < int'(AW); i++) begin
         if (k_q == AW'(i)) begin
            sel_data  = stage_data[i];
            sel_carry = stage_carry[i];
         end
      end
   end

   always_comb begin
      step_data  = rem_q[0] ? sel_data : data_q;
      step_carry = rem_q[0] ? sel_carry : carry_q;
      last_stage = (rem_q >> 1) == '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         data_q  <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         mode_q  <= ModeLsl;
         rem_q   <= '0;
         k_q     <= '0;
      end else if (flush) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         k_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid && ready_q) begin
                  data_q  <= bus.in_data;
                  carry_q <= bus.in_carry;
                  mode_q  <= bus.in_mode;
                  rem_q   <= bus.in_shamt;
                  k_q     <= '0;
                  ready_q <= 1'b0;
                  if (bus.in_shamt == '0) begin
                     state_q <= StDone;
                     valid_q <= 1'b1;
                     zero_q  <= (bus.in_data == '0);
                  end else begin
                     state_q <= StBusy;
                  end
               end
            end
            StBusy: begin
               data_q  <= step_data;
               carry_q <= step_carry;
               rem_q   <= rem_q >> 1;
               k_q     <= k_q + AW'(1);
               if (last_stage) begin
                  state_q <= StDone;
                  valid_q <= 1'b1;
                  zero_q  <= (step_data == '0);
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  state_q <= StIdle;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = ready_q;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_carry = carry_q;
   assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: directed corner cases plus random operations against a one-step shift model.
module tb_shift_unit;

   logic clk = 1'b0;
   logic reset_n;
   logic flush;
   int   n_tests = 0;
   int   n_fail  = 0;

   shift_unit_if #(.WIDTH(64)) bus ();

   shift_unit #(.WIDTH(64)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Whole-shift result computed in one step: {carry, data}.
   function automatic logic [64:0] ref_op(input logic [63:0] d, input int n, input logic [1:0] md,
                                          input logic cin);
      logic [63:0] r;
      logic        c;
      if (n == 0) return {cin, d};
      case (md)
         2'b00: begin r = d << n; c = d[64-n]; end
         2'b01: begin r = d >> n; c = d[n-1]; end
         2'b10: begin r = $signed(d) >>> n; c = d[n-1]; end
         default: begin r = (d >> n) | (d << (64 - n)); c = r[63]; end
      endcase
      return {c, r};
   endfunction

   task automatic run_op(input logic [63:0] d, input int n, input logic [1:0] md, input logic cin,
                         input int hold, input bit noise, input string tag);
      logic [64:0] exp;
      int          lat;
      int          w;
      exp = ref_op(d, n, md, cin);
      w = 0;
      while (!bus.in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_data  = d;
      bus.in_shamt = n[5:0];
      bus.in_mode  = md;
      bus.in_carry = cin;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      if (noise) begin
         // Keep a conflicting request asserted while the unit is busy.
         bus.in_data  = ~d;
         bus.in_shamt = 6'd1;
         bus.in_mode  = ~md;
         bus.in_carry = ~cin;
      end else begin
         bus.in_valid = 1'b0;
      end
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      bus.in_valid = 1'b0;
      check({tag, ".latency"}, 64'(lat), (n == 0) ? 64'd1 : 64'($clog2(n + 1) + 1));
      check({tag, ".data"}, bus.out_data, exp[63:0]);
      check({tag, ".carry"}, 64'(bus.out_carry), 64'(exp[64]));
      check({tag, ".zero"}, 64'(bus.out_zero), 64'(exp[63:0] == 64'd0));
      check({tag, ".busy_rdy"}, 64'(bus.in_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
         check({tag, ".hold_data"}, bus.out_data, exp[63:0]);
         check({tag, ".hold_carry"}, 64'(bus.out_carry), 64'(exp[64]));
         check({tag, ".hold_zero"}, 64'(bus.out_zero), 64'(exp[63:0] == 64'd0));
         check({tag, ".hold_rdy"}, 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, ".post_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, ".post_rdy"}, 64'(bus.in_ready), 64'd1);
   endtask

   // Start a long op, abort it in the second BUSY cycle with flush or reset.
   task automatic abort_op(input bit use_reset, input string tag);
      bus.in_data  = 64'hDEAD_BEEF_0123_4567;
      bus.in_shamt = 6'd63;
      bus.in_mode  = 2'b01;
      bus.in_carry = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      if (use_reset) reset_n = 1'b0;
      else flush = 1'b1;
      @(posedge clk); #1;
      check({tag, ".rdy"}, 64'(bus.in_ready), 64'd1);
      check({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
      if (use_reset) begin
         check({tag, ".data"}, bus.out_data, 64'd0);
         check({tag, ".carry"}, 64'(bus.out_carry), 64'd0);
      end
      reset_n = 1'b1;
      flush   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check({tag, ".quiet"}, 64'(bus.out_valid), 64'd0);
      end
   endtask

   initial begin
      logic [63:0] d;
      int          n;
      logic [1:0]  md;
      reset_n       = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_shamt  = '0;
      bus.in_mode   = '0;
      bus.in_carry  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.in_ready", 64'(bus.in_ready), 64'd1);
      check("reset.out_valid", 64'(bus.out_valid), 64'd0);
      check("reset.out_data", bus.out_data, 64'd0);
      check("reset.out_carry", 64'(bus.out_carry), 64'd0);
      check("reset.out_zero", 64'(bus.out_zero), 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_op(64'h4, 2, 2'b01, 1'b0, 0, 1'b0, "lsr4_2");
      run_op(64'h8000_0000_0000_0000, 63, 2'b10, 1'b0, 0, 1'b0, "asr_63");
      run_op(64'h1, 1, 2'b11, 1'b0, 0, 1'b0, "ror1_1");
      run_op(64'h3, 63, 2'b00, 1'b0, 0, 1'b0, "lsl3_63");
      run_op(64'h5, 0, 2'b00, 1'b1, 0, 1'b0, "lsl5_0");
      run_op(64'h1, 1, 2'b01, 1'b0, 0, 1'b0, "lsr1_1");
      run_op(64'hA5A5_0000_FFFF_1234, 37, 2'b11, 1'b0, 5, 1'b1, "backpressure");

      abort_op(1'b0, "flush");
      run_op(64'hF0F0_F0F0_0000_000F, 12, 2'b00, 1'b0, 0, 1'b0, "after_flush");
      abort_op(1'b1, "reset");
      run_op(64'h8123_4567_89AB_CDEF, 9, 2'b10, 1'b1, 1, 1'b0, "after_reset");

      for (int t = 0; t < 40; t++) begin
         d  = {32'($urandom), 32'($urandom)};
         n  = int'($urandom_range(0, 63));
         md = 2'($urandom_range(0, 3));
         run_op(d, n, md, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
